// File: rtl/fft_pkg.sv
// Shared FFT constants: size, twiddle width, W16^k ROM contents, sequencer state codes
// and the per-entry address decode used by the twiddle sequencer.
package fft_pkg;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int TW_W  = 8;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Q1.7 W16^k for k = 0..7, element [k]; +1.0 saturates to 127.
  localparam logic [7:0][TW_W-1:0] TW_RE_ROM = {
    8'h8B, 8'hA6, 8'hCF, 8'h00, 8'h31, 8'h5A, 8'h75, 8'h7F
  };
  localparam logic [7:0][TW_W-1:0] TW_IM_ROM = {
    8'hCF, 8'hA6, 8'h8B, 8'h81, 8'h8B, 8'hA6, 8'hCF, 8'h00
  };

  typedef struct packed {
    logic [1:0] stage;
    logic [3:0] idx_a;
    logic [3:0] idx_b;
    logic [2:0] k;
  } entry_t;

  // Entry count is {stage, butterfly}; butterfly j splits into group g and position p.
  function automatic entry_t entry_decode(input logic [4:0] cnt);
    entry_t     e;
    logic [1:0] s;
    logic [2:0] j;
    logic [2:0] p;
    logic [2:0] g;
    logic [3:0] m4;
    s        = cnt[4:3];
    j        = cnt[2:0];
    m4       = (4'd1 << s) - 4'd1;
    p        = j & m4[2:0];
    g        = j >> s;
    e.stage  = s;
    e.k      = p << (2'd3 - s);
    e.idx_a  = ({1'b0, g} << (s + 3'd1)) | {1'b0, p};
    e.idx_b  = e.idx_a + (4'd1 << s);
    return e;
  endfunction

endpackage

// File: rtl/twiddle_sequencer_if.sv
// Entry stream from the twiddle sequencer to the butterfly/multiplier datapath.
// master drives the entry and out_valid; slave returns out_ready.
interface twiddle_sequencer_if;

  logic                           out_valid;
  logic                           out_ready;
  logic signed [fft_pkg::TW_W-1:0] w_re;
  logic signed [fft_pkg::TW_W-1:0] w_im;
  logic [1:0]                     stage;
  logic [3:0]                     idx_a;
  logic [3:0]                     idx_b;

  modport master (
    output out_valid, w_re, w_im, stage, idx_a, idx_b,
    input  out_ready
  );

  modport slave (
    input  out_valid, w_re, w_im, stage, idx_a, idx_b,
    output out_ready
  );

endinterface

// File: rtl/twiddle_rom.sv
// W16^k lookup, k = 0..7, signed Q1.7.
// Latency: combinational. Backpressure: none.
module twiddle_rom
  import fft_pkg::*;
(
  input  logic [2:0]             k,
  output logic signed [TW_W-1:0] w_re,
  output logic signed [TW_W-1:0] w_im
);

  assign w_re = TW_RE_ROM[k];
  assign w_im = TW_IM_ROM[k];

endmodule

// File: rtl/twiddle_sequencer.sv
// 16-point radix-2 DIT schedule: 32 (stage, idx_a, idx_b, twiddle) entries per start.
// Latency: entry 0 one cycle after start; registered outputs. Backpressure: holds entry while out_ready=0.
// Optional TWIDDLE_INVERSE_EN adds inv input (sampled with start) for conjugate twiddles.
module twiddle_sequencer
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef TWIDDLE_INVERSE_EN
  input  logic                  inv,
`endif
  output logic                  busy,
  output logic                  done,
  twiddle_sequencer_if.master   tw
);

  state_t                 state;
  logic [4:0]             cnt;
  logic                   inv_q;
  logic                   fire;
  logic                   last;
  logic                   load;
  logic                   inv_sel;
  logic [4:0]             nxt_cnt;
  entry_t                 nxt;
  logic signed [TW_W-1:0] rom_re;
  logic signed [TW_W-1:0] rom_im;
  logic signed [TW_W-1:0] nxt_im;

  assign fire    = tw.out_valid & tw.out_ready;
  assign last    = (cnt == 5'd31);
  assign load    = ((state == ST_IDLE) && start) || ((state == ST_RUN) && fire && !last);
  assign nxt_cnt = (state == ST_IDLE) ? 5'd0 : cnt + 5'd1;
  assign nxt     = entry_decode(nxt_cnt);

`ifdef TWIDDLE_INVERSE_EN
  assign inv_sel = (state == ST_IDLE) ? inv : inv_q;
`else
  assign inv_sel = 1'b0;
`endif

  twiddle_rom u_rom (
    .k    (nxt.k),
    .w_re (rom_re),
    .w_im (rom_im)
  );

  // Table never holds -128, so negation cannot overflow; 0 stays 0.
  assign nxt_im = inv_sel ? -rom_im : rom_im;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= 5'd0;
      inv_q        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tw.out_valid <= 1'b0;
      tw.stage     <= 2'd0;
      tw.idx_a     <= 4'd0;
      tw.idx_b     <= 4'd0;
      tw.w_re      <= '0;
      tw.w_im      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_RUN;
            cnt          <= 5'd0;
            inv_q        <= inv_sel;
            busy         <= 1'b1;
            tw.out_valid <= 1'b1;
          end
        end
        default: begin
          if (fire) begin
            if (last) begin
              state        <= ST_IDLE;
              busy         <= 1'b0;
              done         <= 1'b1;
              tw.out_valid <= 1'b0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
      endcase
      if (load) begin
        tw.stage <= nxt.stage;
        tw.idx_a <= nxt.idx_a;
        tw.idx_b <= nxt.idx_b;
        tw.w_re  <= rom_re;
        tw.w_im  <= nxt_im;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Directed bench for twiddle_sequencer: full schedules, stall, ignored start,
// back-to-back start, mid-run reset, and (with TWIDDLE_INVERSE_EN) conjugate twiddles.
module tb_twiddle_sequencer;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
`ifdef TWIDDLE_INVERSE_EN
  logic inv;
`endif

  twiddle_sequencer_if bus ();

  twiddle_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef TWIDDLE_INVERSE_EN
    .inv   (inv),
`endif
    .busy  (busy),
    .done  (done),
    .tw    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit exp_inv  = 1'b0;

  // Hand-derived schedule tables, indexed by entry = stage*8 + j.
  int EXP_A [32] = '{0,2,4,6,8,10,12,14,  0,1,4,5,8,9,12,13,
                     0,1,2,3,8,9,10,11,   0,1,2,3,4,5,6,7};
  int EXP_B [32] = '{1,3,5,7,9,11,13,15,  2,3,6,7,10,11,14,15,
                     4,5,6,7,12,13,14,15, 8,9,10,11,12,13,14,15};
  int EXP_K [32] = '{0,0,0,0,0,0,0,0,     0,4,0,4,0,4,0,4,
                     0,2,4,6,0,2,4,6,     0,1,2,3,4,5,6,7};
  int ROM_RE [8] = '{127, 117, 90, 49, 0, -49, -90, -117};
  int ROM_IM [8] = '{0, -49, -90, -117, -127, -117, -90, -49};

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_entry(input int e);
    int k;
    int im;
    k  = EXP_K[e];
    im = exp_inv ? -ROM_IM[k] : ROM_IM[k];
    check($sformatf("e%0d_valid", e), int'(bus.out_valid), 1);
    check($sformatf("e%0d_busy", e), int'(busy), 1);
    check($sformatf("e%0d_done", e), int'(done), 0);
    check($sformatf("e%0d_stage", e), int'(bus.stage), e / 8);
    check($sformatf("e%0d_idx_a", e), int'(bus.idx_a), EXP_A[e]);
    check($sformatf("e%0d_idx_b", e), int'(bus.idx_b), EXP_B[e]);
    check($sformatf("e%0d_w_re", e), int'(bus.w_re), ROM_RE[k]);
    check($sformatf("e%0d_w_im", e), int'(bus.w_im), im);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, int'(bus.out_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_stage"}, int'(bus.stage), 0);
    check({tag, "_idx_a"}, int'(bus.idx_a), 0);
    check({tag, "_idx_b"}, int'(bus.idx_b), 0);
    check({tag, "_w_re"}, int'(bus.w_re), 0);
    check({tag, "_w_im"}, int'(bus.w_im), 0);
  endtask

  // Called with entry 0 already on the outputs. Negative arguments disable the feature.
  task automatic run_sched(input int stall_at, input int start_at, input int abort_at,
                           input bit chain);
    for (int e = 0; e < 32; e++) begin
      check_entry(e);
      if (e == abort_at) begin
        rst_n = 1'b0;
        tick();
        check_zero("abort");
        rst_n = 1'b1;
        tick();
        check_zero("after_abort");
        return;
      end
      if (e == stall_at) begin
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          tick();
          check_entry(e);
        end
        bus.out_ready = 1'b1;
      end
      if (e == start_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("end_done", int'(done), 1);
    check("end_valid", int'(bus.out_valid), 0);
    check("end_busy", int'(busy), 0);
    if (chain) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end else begin
      tick();
      check("done_pulse_len", int'(done), 0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.out_ready = 1'b0;
`ifdef TWIDDLE_INVERSE_EN
    inv           = 1'b0;
`endif
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    check_zero("idle");

    // Schedule with a 5-cycle stall at entry 10, a stray start at entry 12,
    // then a new start during the done cycle.
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_sched(10, 12, -1, 1'b1);

    // Back-to-back schedule aborted by reset at entry 20.
    run_sched(-1, -1, 20, 1'b0);

    // Restart after abort begins cleanly at entry 0 and runs to completion.
    start = 1'b1;
    tick();
    start = 1'b0;
    run_sched(-1, -1, -1, 1'b0);

`ifdef TWIDDLE_INVERSE_EN
    inv     = 1'b1;
    exp_inv = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    inv   = 1'b0;
    run_sched(-1, -1, -1, 1'b0);
    exp_inv = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
